alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised RISC-V execute-stage unit that combines ALU-control decode (ALUOp/funct7/funct3 → 4-bit op code) with a WIDTH-bit ALU behind a valid/ready handshake. It sits between the ID/EX register and the EX/MEM register. It extends the original AND/OR/ADD/SUB decoder to the full RV32I R-type set. It also supports an optional iterative multi-cycle multiply, so operations have variable latency.

## Interface
- WIDTH, 32, operand/result width (≥ 8, power of two); shift amount = b[$clog2(WIDTH)-1:0]
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept; combinational: (state==IDLE) | (state==DONE & out_ready)
- alu_op  input  2  00 load/store add, x1 branch subtract, 10 R-type
- funct7  input  7  instruction funct7
- funct3  input  3  instruction funct3
- a, b  input  WIDTH  operands
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0)
- code  output  4  registered decoded op code
- illegal  output  1  registered; decode was illegal

## Operation
- Decode:
  - alu_op 00 → ADD 0010; alu_op 01/11 → SUB 0110.
  - alu_op 10 with funct7 0000000: funct3 000 ADD, 001 SLL 0100, 010 SLT 1000, 011 SLTU 1001, 100 XOR 0011, 101 SRL 0101, 110 OR 0001, 111 AND 0000.
  - alu_op 10 with funct7 0100000: funct3 000 SUB, 101 SRA 0111; any other funct3 is illegal.
  - alu_op 10 with funct7 0000001 and funct3 000 → MUL 1010 (see Configuration).
  - Every other alu_op-10 combination → illegal: code 1111, result 0, illegal=1.
- Arithmetic is modulo 2^WIDTH; SUB wraps. SLT is a signed compare and SLTU unsigned; both give 0/1 in bit 0 with upper bits zero. SRA replicates a[WIDTH-1].
- FSM:
  - IDLE: accept on in_valid & in_ready. Single-cycle op or illegal → DONE. MUL → BUSY.
  - BUSY: shift-add, one multiplier bit per cycle, WIDTH cycles, then → DONE. in_ready=0.
  - DONE: out_valid=1. result/zero/code/illegal are held stable until out_ready. On out_ready: → IDLE, or accept a new op in the same cycle if in_valid (back-to-back).
- Operands, alu_op and funct fields are captured at accept; later input changes have no effect.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, out_valid 0, result 0, zero 0, code 0000, illegal 0, multiply accumulators 0.
- Single-cycle and illegal ops: accepted at edge N, out_valid=1 after edge N+1 (latency 1).
- MUL: latency WIDTH+1 edges from accept to out_valid.
- Throughput: one single-cycle op per clock while out_ready=1.
- Reset during BUSY or DONE aborts the op; no result is presented; in_ready=1 on the first cycle after rst_n returns high.
- out_ready while out_valid=0 has no effect.

## Configuration
- ALU_MUL_EN defined: MUL is decoded and executed iteratively as above. result = low WIDTH bits of a*b (sign-agnostic).
- ALU_MUL_EN undefined: no BUSY state or multiply datapath is synthesised. funct7 0000001 decodes as illegal with latency 1.

## Test plan
- ADD: alu_op=10, f7=0, f3=000, a=5, b=7 → one cycle later out_valid=1, result=12, code=0010, zero=0, illegal=0.
- Branch SUB: alu_op=01, a=b=0x1234 → result=0, zero=1, code=0110. Also check alu_op=11, a=3, b=5 → result=0xFFFFFFFE.
- Shifts/compares (WIDTH=32):
  - SRA a=0x80000000, b=0x24 → 0xF8000000.
  - SRL same operands → 0x08000000.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLTU same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles → result/code stable, in_ready=0. Then assert out_ready=1 with in_valid=1 (OR 0xF0|0x0F) → accepted that cycle, next result 0xFF.
- MUL:
  - With ALU_MUL_EN: a=0xFFFFFFFF, b=3 → result 0xFFFFFFFD, out_valid exactly 33 edges after accept.
  - Without ALU_MUL_EN: illegal=1, code=1111, result=0 after 1 cycle.
  - f7=0100000, f3=110 → illegal in both builds.
- Reset mid-MUL: assert rst_n=0 at BUSY cycle 10 → out_valid stays 0, all outputs at reset values, in_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
//
// RISC-V execute-stage unit: ALU-control decode (alu_op/funct7/funct3 to a
// 4-bit op code) feeding a WIDTH-bit ALU, wrapped in a valid/ready handshake.
// Single-cycle ops and illegal encodings finish one edge after accept. When
// the ALU_MUL_EN macro is defined, funct7=0000001/funct3=000 selects an
// iterative shift-add multiply that takes WIDTH extra edges. With ALU_MUL_EN
// undefined, no multiply datapath or BUSY state exists and that encoding is
// reported as illegal.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation offered
//   in_ready   unit can accept (IDLE, or DONE with out_ready)
//   alu_op     00 load/store add, x1 branch subtract, 10 R-type
//   funct7     instruction funct7
//   funct3     instruction funct3
//   a, b       operands (shift amount is b[$clog2(WIDTH)-1:0])
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     registered result
//   zero       registered (result == 0)
//   code       registered decoded op code
//   illegal    registered; decode was illegal
// ----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       code,
    output logic             illegal
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_ILL  = 4'b1111;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [3:0]       code_q, code_d;
    logic             illegal_q, illegal_d;

    logic [3:0]       dec_code;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifts left each step
    logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifts right each step
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mul_sum;
`endif

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign code      = code_q;
    assign illegal   = illegal_q;

    // ------------------------------------------------------------------
    // ALU-control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        dec_code    = OP_ILL;
        dec_illegal = 1'b1;
        case (alu_op)
            2'b00: begin
                dec_code    = OP_ADD;
                dec_illegal = 1'b0;
            end
            2'b01, 2'b11: begin
                dec_code    = OP_SUB;
                dec_illegal = 1'b0;
            end
            default: begin
                case (funct7)
                    7'b0000000: begin
                        dec_illegal = 1'b0;
                        case (funct3)
                            3'b000:  dec_code = OP_ADD;
                            3'b001:  dec_code = OP_SLL;
                            3'b010:  dec_code = OP_SLT;
                            3'b011:  dec_code = OP_SLTU;
                            3'b100:  dec_code = OP_XOR;
                            3'b101:  dec_code = OP_SRL;
                            3'b110:  dec_code = OP_OR;
                            default: dec_code = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            dec_code    = OP_SUB;
                            dec_illegal = 1'b0;
                        end else if (funct3 == 3'b101) begin
                            dec_code    = OP_SRA;
                            dec_illegal = 1'b0;
                        end
                    end
`ifdef ALU_MUL_EN
                    7'b0000001: begin
                        if (funct3 == 3'b000) begin
                            dec_code    = OP_MUL;
                            dec_illegal = 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU (illegal and multiply codes yield 0 here)
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (dec_code)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_XOR:  alu_res = a ^ b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << b[SH_W-1:0];
            OP_SRL:  alu_res = a >> b[SH_W-1:0];
            OP_SRA:  alu_res = $unsigned($signed(a) >>> b[SH_W-1:0]);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        code_d    = code_q;
        illegal_d = illegal_q;
`ifdef ALU_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
                // Accepting here also covers the back-to-back case in DONE.
                if (accept) begin
                    code_d    = dec_code;
                    illegal_d = dec_illegal;
`ifdef ALU_MUL_EN
                    if (dec_code == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
`else
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    state_d  = S_DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SH_W'(1);
                if (cnt_q == SH_W'(WIDTH - 1)) begin
                    result_d = mul_sum;
                    zero_d   = (mul_sum == '0);
                    state_d  = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            code_q    <= 4'b0000;
            illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            code_q    <= code_d;
            illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule
